// File: rtl/memory_access_if.sv
// memory_access_if: bundles the EX->MA pipeline inputs, the WB registers,
// the MA->EX forwarding path and the data-memory debug port.
interface memory_access_if #(
  parameter int NB_DATA           = 32,
  parameter int NB_ADDR_REGISTERS = 5,
  parameter int NB_CONTROL_MA     = 5,
  parameter int NB_CONTROL_WB     = 2,
  parameter int NB_CONTROL_MA_WB  = NB_CONTROL_MA + NB_CONTROL_WB,
  parameter int NB_ADDR_MEM       = 8
);
  logic                         i_enable;
  logic [NB_CONTROL_MA_WB-1:0]  i_control_ma_wb;
  logic [NB_DATA-1:0]           i_result;
  logic [NB_DATA-1:0]           i_w_data_mem;
  logic [NB_ADDR_REGISTERS-1:0] i_rd_num;
  logic [NB_ADDR_MEM-1:0]       i_debug_addr;
  logic [NB_CONTROL_WB-1:0]     o_control_wb;
  logic [NB_DATA-1:0]           o_mem_data;
  logic [NB_DATA-1:0]           o_alu_result;
  logic [NB_ADDR_REGISTERS-1:0] o_rd_num;
  logic [NB_DATA-1:0]           o_ex_rd_data;
  logic [NB_ADDR_REGISTERS-1:0] o_ex_rd_num;
  logic                         o_ex_ctl_rw;
  logic [NB_DATA-1:0]           o_debug_data;
  modport master (
    output i_enable, i_control_ma_wb, i_result, i_w_data_mem, i_rd_num, i_debug_addr,
    input  o_control_wb, o_mem_data, o_alu_result, o_rd_num, o_ex_rd_data, o_ex_rd_num,
           o_ex_ctl_rw, o_debug_data
  );
  modport slave (
    input  i_enable, i_control_ma_wb, i_result, i_w_data_mem, i_rd_num, i_debug_addr,
    output o_control_wb, o_mem_data, o_alu_result, o_rd_num, o_ex_rd_data, o_ex_rd_num,
           o_ex_ctl_rw, o_debug_data
  );
endinterface

// File: rtl/memory_access.sv
// memory_access: MIPS MA stage with word-organised data memory, byte/half
// lane merge on stores, sign/zero-extended loads and MA->EX forwarding.
module memory_access #(
  parameter int NB_DATA           = 32,
  parameter int NB_ADDR_REGISTERS = 5,
  parameter int NB_CONTROL_MA     = 5,
  parameter int NB_CONTROL_WB     = 2,
  parameter int NB_CONTROL_MA_WB  = NB_CONTROL_MA + NB_CONTROL_WB,
  parameter int NB_ADDR_MEM       = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  memory_access_if.slave   bus
);
  logic [NB_DATA-1:0]           mem_q [2**NB_ADDR_MEM] = '{default: '0};
  logic [NB_CONTROL_WB-1:0]     control_wb_q;
  logic [NB_DATA-1:0]           mem_data_q, alu_result_q, mem_data_d, rword, wword, mask, wrep;
  logic [NB_ADDR_REGISTERS-1:0] rd_num_q;
  logic [NB_ADDR_MEM-1:0]       widx;
  logic [1:0]                   b;
  logic [7:0]                   bv;
  logic [15:0]                  hv;
  logic                         is_b, is_h, sx;
  assign widx = bus.i_result[NB_ADDR_MEM+1:2];
  assign b    = bus.i_result[1:0];
  assign is_b = bus.i_control_ma_wb[4:3] == 2'b00;
  assign is_h = bus.i_control_ma_wb[4:3] == 2'b01;
  assign sx   = ~bus.i_control_ma_wb[2];
  always_comb begin
    rword      = mem_q[widx];
    bv         = rword[{b, 3'b000} +: 8];
    hv         = b[1] ? rword[31:16] : rword[15:0];
    mem_data_d = is_b ? {{24{sx & bv[7]}}, bv} : is_h ? {{16{sx & hv[15]}}, hv} : rword;
    mask       = is_b ? 32'h0000_00FF << {b, 3'b000} : is_h ? (b[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) : '1;
    wrep       = is_b ? {4{bus.i_w_data_mem[7:0]}} : is_h ? {2{bus.i_w_data_mem[15:0]}} : bus.i_w_data_mem;
    wword      = (rword & ~mask) | (wrep & mask);
  end
  // Memory is not reset; only the store is gated by reset and stall.
  always_ff @(posedge i_clk)
    if (!i_reset && bus.i_enable && bus.i_control_ma_wb[5]) mem_q[widx] <= wword;
  always_ff @(posedge i_clk)
    if (i_reset) begin
      control_wb_q <= '0;
      mem_data_q   <= '0;
      alu_result_q <= '0;
      rd_num_q     <= '0;
    end else if (bus.i_enable) begin
      control_wb_q <= bus.i_control_ma_wb[1:0];
      mem_data_q   <= mem_data_d;
      alu_result_q <= bus.i_result;
      rd_num_q     <= bus.i_rd_num;
    end
  assign bus.o_control_wb = control_wb_q;
  assign bus.o_mem_data   = mem_data_q;
  assign bus.o_alu_result = alu_result_q;
  assign bus.o_rd_num     = rd_num_q;
  assign bus.o_ex_rd_data = bus.i_control_ma_wb[1] ? mem_data_d : bus.i_result;
  assign bus.o_ex_rd_num  = bus.i_rd_num;
  assign bus.o_ex_ctl_rw  = bus.i_control_ma_wb[0];
  assign bus.o_debug_data = mem_q[bus.i_debug_addr];
endmodule
